// File: rtl/stream_pkg.sv
// Shared width helpers for the stream FIFO family.
package stream_pkg;

   // Width needed to hold a fill level of 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer width; never collapses to zero bits.
   function automatic int unsigned ptr_width(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with registered handshake flags, fill level and synchronous flush.
module stream_fifo
   import stream_pkg::*;
#(
   parameter type         data_t = logic [7:0],
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  data_t            data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output data_t            data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] usage_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   data_t            mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic             valid_q, valid_nxt;
   logic             ready_q, ready_nxt;
   logic             push, pop;

   // Handshakes qualified only by registered flags, so no input-to-output path exists.
   assign push = valid_i & ready_q;
   assign pop  = valid_q & ready_i;

   // Next-state for pointers, count and the registered full/empty flags.
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      count_nxt  = count;
      if (push) begin
         wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      if (flush_i) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         count_nxt  = '0;
      end
      valid_nxt = (count_nxt != '0);
      ready_nxt = (count_nxt != CNT_FULL);
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr_nxt;
         count   <= count_nxt;
         valid_q <= valid_nxt;
         ready_q <= ready_nxt;
      end
   end

   // Storage is not reset; a write during flush is harmless since pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= data_i;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign usage_o = count;
   assign data_o  = mem[rd_ptr];

`ifndef SYNTHESIS
   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      count <= CNT_FULL);

   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (count == CNT_FULL)));

   a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and randomized scoreboard bench for stream_fifo (DEPTH=4, 8-bit data).
module tb_stream_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             flush_i;
   logic [7:0]       data_i;
   logic             valid_i;
   logic             ready_o;
   logic [7:0]       data_o;
   logic             valid_o;
   logic             ready_i;
   logic [CNT_W-1:0] usage_o;

   int checks   = 0;
   int failures = 0;
   int popped   = 0;
   logic [7:0] sb [$];

   stream_fifo #(.data_t(logic [7:0]), .DEPTH(DEPTH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .usage_o (usage_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare outputs with the model mid-cycle, then advance the model.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
      int  n;
      bit  do_push, do_pop;
      logic [7:0] exp;
      valid_i = v;
      data_i  = d;
      ready_i = r;
      flush_i = f;
      @(negedge clk_i);
      n = sb.size();
      chk("valid", 32'(valid_o), 32'(n != 0));
      chk("ready", 32'(ready_o), 32'(n != DEPTH));
      chk("usage", 32'(usage_o), 32'(n));
      do_push = v && (n != DEPTH);
      do_pop  = r && (n != 0);
      if (do_pop) begin
         exp = sb.pop_front();
         chk("data", 32'(data_o), 32'(exp));
         popped++;
      end
      if (do_push) sb.push_back(d);
      if (f) sb.delete();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_i = 1'b1; flush_i = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b0;

      // Reset then idle
      #3;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_usage", 32'(usage_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Fill to full with consumer stalled
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      chk("fill_u1", 32'(usage_o), 32'd1);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      chk("fill_u2", 32'(usage_o), 32'd2);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      chk("fill_u3", 32'(usage_o), 32'd3);
      cycle(1'b1, 8'h44, 1'b0, 1'b0);
      chk("fill_u4", 32'(usage_o), 32'd4);
      chk("full_ready", 32'(ready_o), 32'd0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      chk("full_reject", 32'(usage_o), 32'd4);
      chk("head_11", 32'(data_o), 32'h11);

      // Drain in order
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", 32'(valid_o), 32'd0);
      chk("drain_usage", 32'(usage_o), 32'd0);

      // Wrap with continuous push&pop at usage 2
      cycle(1'b1, 8'h60, 1'b0, 1'b0);
      cycle(1'b1, 8'h61, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'(8'h62 + i), 1'b1, 1'b0);
         chk("wrap_usage", 32'(usage_o), 32'd2);
      end
      repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_empty", 32'(usage_o), 32'd0);

      // Full with simultaneous valid/ready: pop only
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h7f, 1'b1, 1'b0);
      chk("fullpop_usage", 32'(usage_o), 32'd3);
      chk("fullpop_ready", 32'(ready_o), 32'd1);

      // Flush at usage 3 with a coincident push
      cycle(1'b1, 8'hAA, 1'b0, 1'b1);
      chk("flush_usage", 32'(usage_o), 32'd0);
      chk("flush_valid", 32'(valid_o), 32'd0);
      chk("flush_ready", 32'(ready_o), 32'd1);
      repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset between edges
      cycle(1'b1, 8'h81, 1'b0, 1'b0);
      cycle(1'b1, 8'h82, 1'b0, 1'b0);
      valid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_usage", 32'(usage_o), 32'd0);
      chk("arst_ready", 32'(ready_o), 32'd1);
      sb.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Random soak
      popped = 0;
      guard  = 0;
      while (popped < 10000 && guard < 60000) begin
         cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0);
         guard++;
      end
      chk("soak_done", 32'(popped), 32'd10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
